// File: rtl/semaforo_pkg.sv
// Shared types and display codes for the
// single-way traffic light sequencer.
package semaforo_pkg;

  typedef enum logic [1:0] {
    PARE    = 2'd0,
    SIGA    = 2'd1,
    ATENCAO = 2'd2,
    PISCA   = 2'd3
  } estado_t;

  localparam logic [7:0] SEG_P   = 8'h73;
  localparam logic [7:0] SEG_A   = 8'h77;
  localparam logic [7:0] SEG_S   = 8'h6D;
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/semaforo_timer.sv
// Phase counter: counts up to a limit, wraps on
// expiry, and is cleared whenever the FSM changes state.
module semaforo_timer #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [CNT_BITS-1:0] lim_i,
  output logic [CNT_BITS-1:0] cnt_o,
  output logic                exp_o
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  assign exp_o = (cnt_q == lim_i);
  assign cnt_o = cnt_q;

  // Next count: restart on state change or on reaching the limit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || exp_o) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/semaforo_controlador.sv
// Timed PARE/SIGA/ATENCAO sequencer with pedestrian
// request latch and flashing maintenance mode.
module semaforo_controlador
  import semaforo_pkg::*;
#(
  parameter int T_PARE     = 6,
  parameter int T_SIGA     = 8,
  parameter int T_ATENCAO  = 3,
  parameter int T_MIN_SIGA = 2,
  parameter int BLINK_HALF = 2,
  parameter int CNT_BITS   = 4
) (
  input  logic                clk_2,
  input  logic                reset,
  input  logic                ped_req,
  input  logic                manut,
  output logic                pare,
  output logic                atencao,
  output logic                siga,
  output logic                ped_pend,
  output logic                ped_ack,
  output logic [CNT_BITS-1:0] tempo,
  output logic [7:0]          seg
);

  localparam logic [CNT_BITS-1:0] L_PARE =
    CNT_BITS'(T_PARE - 1);
  localparam logic [CNT_BITS-1:0] L_SIGA =
    CNT_BITS'(T_SIGA - 1);
  localparam logic [CNT_BITS-1:0] L_ATEN =
    CNT_BITS'(T_ATENCAO - 1);
  localparam logic [CNT_BITS-1:0] L_MIN =
    CNT_BITS'(T_MIN_SIGA - 1);
  localparam logic [CNT_BITS-1:0] L_BLINK =
    CNT_BITS'(BLINK_HALF - 1);

  estado_t             state_q;
  estado_t             state_d;
  logic                blink_q;
  logic                pend_q;
  logic                ack_q;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] lim;
  logic                expd;
  logic                clr;
  logic [7:0]          code;

  // Phase length selected by the current state.
  always_comb begin
    lim = L_PARE;
    unique case (state_q)
      PARE:    lim = L_PARE;
      SIGA:    lim = L_SIGA;
      ATENCAO: lim = L_ATEN;
      PISCA:   lim = L_BLINK;
    endcase
  end

  assign clr = (state_d != state_q);

  semaforo_timer #(
    .CNT_BITS(CNT_BITS)
  ) u_timer (
    .clk_i (clk_2),
    .rst_i (reset),
    .clr_i (clr),
    .lim_i (lim),
    .cnt_o (cnt),
    .exp_o (expd)
  );

  // Next state: maintenance first, then timer and early SIGA end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PARE: begin
        if (manut)     state_d = PISCA;
        else if (expd) state_d = SIGA;
      end
      SIGA: begin
        if (manut)
          state_d = PISCA;
        else if (expd || (pend_q && cnt >= L_MIN))
          state_d = ATENCAO;
      end
      ATENCAO: begin
        if (manut)     state_d = PISCA;
        else if (expd) state_d = PARE;
      end
      PISCA: begin
        if (!manut) state_d = PARE;
      end
    endcase
  end

  // State, pedestrian latch, ack pulse and flash phase.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= PARE;
      blink_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= pend_q && (state_d == PARE)
                 && (state_q != PARE);
      if (state_d == PARE || state_d == PISCA)
        pend_q <= 1'b0;
      else if (ped_req &&
               (state_q == SIGA || state_q == ATENCAO))
        pend_q <= 1'b1;
      if (state_d != PISCA)
        blink_q <= 1'b0;
      else if (state_q != PISCA)
        blink_q <= 1'b1;
      else if (expd)
        blink_q <= ~blink_q;
    end
  end

  // Display code for the lit phase.
  always_comb begin
    code = SEG_P;
    unique case (state_q)
      PARE:    code = SEG_P;
      SIGA:    code = SEG_S;
      ATENCAO: code = SEG_A;
      PISCA:   code = blink_q ? SEG_A : SEG_OFF;
    endcase
  end

  assign pare     = (state_q == PARE);
  assign siga     = (state_q == SIGA);
  assign atencao  = (state_q == ATENCAO)
                    || (state_q == PISCA && blink_q);
  assign ped_pend = pend_q;
  assign ped_ack  = ack_q;
  assign tempo    = (state_q == PISCA) ? '0 : lim - cnt;
  assign seg      = {pend_q, code[6:0]};

endmodule

// File: tb/tb_semaforo_controlador.sv
// Scoreboard bench: driver queues expected outputs,
// monitor compares them one cycle at a time.
module tb_semaforo_controlador;

  typedef struct {
    logic       pare;
    logic       aten;
    logic       siga;
    logic       pend;
    logic       ack;
    logic [3:0] tempo;
    logic [7:0] seg;
    string      tag;
  } exp_t;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       ped_req = 1'b0;
  logic       manut = 1'b0;
  logic       pare, atencao, siga;
  logic       ped_pend, ped_ack;
  logic [3:0] tempo;
  logic [7:0] seg;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  string cur_tag = "";

  semaforo_controlador dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .ped_req  (ped_req),
    .manut    (manut),
    .pare     (pare),
    .atencao  (atencao),
    .siga     (siga),
    .ped_pend (ped_pend),
    .ped_ack  (ped_ack),
    .tempo    (tempo),
    .seg      (seg)
  );

  always #5 clk_2 = ~clk_2;

  // ph: P,S,A = lit phase; Y = flash on; X = flash off
  function automatic exp_t E(byte ph, int t,
                             bit pd, bit ak);
    exp_t e;
    logic [7:0] c;
    e.pare  = (ph == "P");
    e.siga  = (ph == "S");
    e.aten  = (ph == "A") || (ph == "Y");
    e.pend  = pd;
    e.ack   = ak;
    e.tempo = 4'(t);
    case (ph)
      "P":     c = 8'h73;
      "S":     c = 8'h6D;
      "A":     c = 8'h77;
      "Y":     c = 8'h77;
      default: c = 8'h00;
    endcase
    e.seg = {pd, c[6:0]};
    e.tag = cur_tag;
    return e;
  endfunction

  task automatic step(bit r, bit p, bit m, exp_t e);
    reset   = r;
    ped_req = p;
    manut   = m;
    q.push_back(e);
    @(posedge clk_2);
    #2;
  endtask

  task automatic run(byte ph, int hi, bit p, bit pd);
    for (int t = hi; t >= 0; t--)
      step(0, p, 0, E(ph, t, pd, 0));
  endtask

  // Monitor: one expected entry per clock edge.
  always @(posedge clk_2) begin
    #1;
    n_chk++;
    if (!$onehot0({pare, atencao, siga})) begin
      n_fail++;
      $display("FAIL onehot: got %b%b%b required at most one",
               pare, atencao, siga);
    end
    n_chk++;
    if (ped_ack && !pare) begin
      n_fail++;
      $display("FAIL ack_pare: got ack=1 pare=0 required pare=1");
    end
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (pare !== e.pare || atencao !== e.aten ||
          siga !== e.siga || ped_pend !== e.pend ||
          ped_ack !== e.ack || tempo !== e.tempo ||
          seg !== e.seg) begin
        n_fail++;
        $display({"FAIL %s: got p%b a%b s%b pend%b ack%b ",
                  "t%0d seg%h required p%b a%b s%b pend%b ",
                  "ack%b t%0d seg%h"}, e.tag,
                 pare, atencao, siga, ped_pend, ped_ack,
                 tempo, seg, e.pare, e.aten, e.siga,
                 e.pend, e.ack, e.tempo, e.seg);
      end
    end
  end

  initial begin
    #2;
    cur_tag = "reset";
    step(1, 0, 0, E("P", 5, 0, 0));

    cur_tag = "free_run";
    run("P", 4, 0, 0);
    run("S", 7, 0, 0);
    run("A", 2, 0, 0);
    run("P", 5, 0, 0);

    cur_tag = "ped_pulse";
    step(0, 0, 0, E("S", 7, 0, 0));
    step(0, 1, 0, E("S", 6, 1, 0));
    step(0, 0, 0, E("A", 2, 1, 0));
    step(0, 0, 0, E("A", 1, 1, 0));
    step(0, 0, 0, E("A", 0, 1, 0));
    step(0, 0, 0, E("P", 5, 0, 1));
    step(0, 0, 0, E("P", 4, 0, 0));

    cur_tag = "ped_held";
    run("P", 3, 1, 0);
    step(0, 1, 0, E("S", 7, 0, 0));
    step(0, 1, 0, E("S", 6, 1, 0));
    step(0, 1, 0, E("A", 2, 1, 0));
    step(0, 0, 0, E("A", 1, 1, 0));
    step(0, 0, 0, E("A", 0, 1, 0));
    step(0, 0, 0, E("P", 5, 0, 1));
    step(0, 0, 0, E("P", 4, 0, 0));

    cur_tag = "manut";
    run("P", 3, 0, 0);
    step(0, 0, 0, E("S", 7, 0, 0));
    step(0, 0, 0, E("S", 6, 0, 0));
    step(0, 0, 0, E("S", 5, 0, 0));
    step(0, 0, 1, E("Y", 0, 0, 0));
    step(0, 1, 1, E("Y", 0, 0, 0));
    step(0, 1, 1, E("X", 0, 0, 0));
    step(0, 0, 1, E("X", 0, 0, 0));
    step(0, 0, 1, E("Y", 0, 0, 0));
    step(0, 0, 1, E("Y", 0, 0, 0));
    step(0, 0, 0, E("P", 5, 0, 0));
    step(0, 0, 0, E("P", 4, 0, 0));

    cur_tag = "ped_on_expiry";
    run("P", 3, 0, 0);
    run("S", 7, 0, 0);
    step(0, 1, 0, E("A", 2, 1, 0));
    step(0, 0, 0, E("A", 1, 1, 0));
    step(0, 0, 0, E("A", 0, 1, 0));
    step(0, 0, 0, E("P", 5, 0, 1));
    step(0, 0, 0, E("P", 4, 0, 0));

    cur_tag = "reset_in_aten";
    run("P", 3, 0, 0);
    step(0, 0, 0, E("S", 7, 0, 0));
    step(0, 1, 0, E("S", 6, 1, 0));
    step(0, 0, 0, E("A", 2, 1, 0));
    step(0, 0, 0, E("A", 1, 1, 0));
    step(1, 0, 0, E("P", 5, 0, 0));
    step(0, 0, 0, E("P", 4, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk_2);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
